// File: rtl/lsu_ctrl.sv
// Load/store control stage: checks a single request, issues a word-addressed,
// byte-strobed memory transaction with timeout, and returns extended load data.
module lsu_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_waddr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t             r_state, w_next_state;
  logic [2:0]         r_func3;
  logic [1:0]         r_alo;
  logic [7:0]         r_cnt;
  logic               r_mem_req, r_mem_we;
  logic [ADDR_W-3:0]  r_mem_waddr;
  logic [3:0]         r_mem_wstrb;
  logic [31:0]        r_mem_wdata, r_resp_rdata;
  logic [1:0]         r_resp_err;

  logic               w_illegal, w_misal, w_oor, w_timeout;
  logic [1:0]         w_req_err;
  logic [3:0]         w_strb;
  logic [31:0]        w_lane, w_load;

  // Request checks, in priority order: illegal func3, misaligned, out of range.
  always_comb begin
    w_illegal = req_is_store ? (req_func3 > 3'd2)
                             : (req_func3 == 3'd3 || req_func3[2:1] == 2'b11);
    w_misal   = (req_func3[1:0] == 2'b01 && req_addr[0]) ||
                (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    w_oor     = |req_addr[31:ADDR_W];
    if (w_illegal)    w_req_err = 2'b11;
    else if (w_misal) w_req_err = 2'b01;
    else if (w_oor)   w_req_err = 2'b10;
    else              w_req_err = 2'b00;
    case (req_func3[1:0])
      2'b00:   w_strb = 4'b0001 << req_addr[1:0];
      2'b01:   w_strb = 4'b0011 << req_addr[1:0];
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_lane = mem_rdata >> {r_alo, 3'b000};
    case (r_func3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {24'h0, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load = {16'h0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // An ack on the final counted cycle takes precedence over the timeout.
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next_state = (w_req_err != 2'b00) ? S_RESP : S_MEM;
      S_MEM:  if (mem_ack || w_timeout) w_next_state = S_RESP;
      S_RESP: if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3      <= '0;
      r_alo        <= '0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wstrb  <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_func3 <= req_func3;
          r_alo   <= req_addr[1:0];
          r_cnt   <= '0;
          if (w_req_err == 2'b00) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= req_is_store;
            r_mem_waddr <= req_addr[ADDR_W-1:2];
            r_mem_wstrb <= w_strb;
            r_mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
          end else begin
            r_resp_err   <= w_req_err;
            r_resp_rdata <= '0;
          end
        end
        S_MEM: begin
          if (mem_ack || w_timeout) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wstrb  <= '0;
            r_mem_wdata  <= '0;
            r_resp_err   <= mem_ack ? 2'b00 : 2'b10;
            r_resp_rdata <= (mem_ack && !r_mem_we) ? w_load : '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: if (resp_ready) begin
          r_resp_err   <= '0;
          r_resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [8:0]  mem_waddr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(11), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accepting edge; returns 1 ns after it.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = st; req_func3 = f3;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Zero-wait load: ack in the first mem_req cycle, then check and drain response.
  task automatic load0(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {30'h0, resp_err}, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic fault(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [1:0] exp_err);
    issue(st, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {30'h0, resp_err}, {30'h0, exp_err});
    chk({tag, "_nomem"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_nomem2"}, {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    resp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_waddr", {23'h0, mem_waddr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp", {30'h0, resp_err}, 32'h0);
    #10 rst_n = 1'b1;
    step();

    // Aligned LW, ack one cycle after mem_req rises.
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_req", {31'h0, mem_req}, 32'h1);
    chk("lw_waddr", {23'h0, mem_waddr}, 32'h4);
    chk("lw_wstrb", {28'h0, mem_wstrb}, 32'hF);
    chk("lw_we", {31'h0, mem_we}, 32'h0);
    chk("lw_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("lw_req_hold", {31'h0, mem_req}, 32'h1);
    chk("lw_noresp", {31'h0, resp_valid}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8081_8283;
    step();
    mem_ack = 1'b0;
    chk("lw_valid", {31'h0, resp_valid}, 32'h1);
    chk("lw_rdata", resp_rdata, 32'h8081_8283);
    chk("lw_err", {30'h0, resp_err}, 32'h0);
    chk("lw_req_drop", {31'h0, mem_req}, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("lw_done_valid", {31'h0, resp_valid}, 32'h0);
    chk("lw_done_ready", {31'h0, req_ready}, 32'h1);

    // Byte/half extension.
    load0("lb",  3'b000, 32'h13, 32'h8000_0000, 32'hFFFF_FF80);
    load0("lbu", 3'b100, 32'h13, 32'h8000_0000, 32'h0000_0080);
    load0("lh",  3'b001, 32'h12, 32'hF00D_0000, 32'hFFFF_F00D);
    load0("lhu", 3'b101, 32'h12, 32'hF00D_0000, 32'h0000_F00D);
    load0("lb0", 3'b000, 32'h04, 32'h0000_007F, 32'h0000_007F);

    // ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_valid", {31'h0, resp_valid}, 32'h0);
    chk("idle_ack_ready", {31'h0, req_ready}, 32'h1);

    // Stores.
    issue(1'b1, 3'b000, 32'h7, 32'h1234_56AB);
    chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    chk("sb_we", {31'h0, mem_we}, 32'h1);
    chk("sb_waddr", {23'h0, mem_waddr}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("sb_rdata", resp_rdata, 32'h0);
    chk("sb_err", {30'h0, resp_err}, 32'h0);
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    issue(1'b1, 3'b001, 32'h6, 32'h0000_BEEF);
    chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_0000);
    chk("sh_we", {31'h0, mem_we}, 32'h1);
    step();
    chk("sh_hold_wdata", mem_wdata, 32'hBEEF_0000);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("sh_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Faults, all responding one cycle after acceptance.
    fault("lw_mis",   1'b0, 3'b010, 32'h2,    2'b01);
    fault("lh_oor",   1'b0, 3'b001, 32'h1000, 2'b10);
    fault("ld_ill",   1'b0, 3'b011, 32'h0,    2'b11);
    fault("ill_prio", 1'b0, 3'b111, 32'h1001, 2'b11);
    fault("sw_ill",   1'b1, 3'b100, 32'h0,    2'b11);
    fault("mis_prio", 1'b1, 3'b010, 32'h1002, 2'b01);

    // Timeout: mem_req held 16 cycles, then access fault.
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_req_%0d", i), {31'h0, mem_req}, 32'h1);
      step();
    end
    chk("to_req_drop", {31'h0, mem_req}, 32'h0);
    chk("to_valid", {31'h0, resp_valid}, 32'h1);
    chk("to_err", {30'h0, resp_err}, 32'h2);
    chk("to_rdata", resp_rdata, 32'h0);
    req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_valid_%0d", i), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("bp_err_%0d", i), {30'h0, resp_err}, 32'h2);
      chk($sformatf("bp_ready_%0d", i), {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1; step(); resp_ready = 1'b0;
    chk("bp_release", {31'h0, resp_valid}, 32'h0);
    chk("bp_no_accept", {31'h0, mem_req}, 32'h0);

    // Async reset during MEM.
    issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
    chk("ar_req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mem_req", {31'h0, mem_req}, 32'h0);
    chk("ar_mem_we", {31'h0, mem_we}, 32'h0);
    chk("ar_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("ar_req_ready", {31'h0, req_ready}, 32'h1);
    #10 rst_n = 1'b1;
    step();
    chk("ar_post_ready", {31'h0, req_ready}, 32'h1);
    chk("ar_post_req", {31'h0, mem_req}, 32'h0);
    load0("ar_lw", 3'b010, 32'h7FC, 32'h0102_0304, 32'h0102_0304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the byte-addressed data memory.
- Accepts one load or store request from the execute stage and performs alignment and range checks.
- Converts the request into a word-addressed, byte-strobed memory transaction with req/ack handshake and timeout, then returns sign/zero-extended load data or an error code to writeback.
- func3 encodings follow RV32I: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.

Parameters:
- ADDR_W, 11, byte-address width of the data memory (2048 bytes).
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack before an access fault; legal range 2..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  LSU can accept a request
- req_is_store  input  1  1=store, 0=load
- req_func3  input  3  access size/sign
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- mem_req  output  1  memory transaction request
- mem_we  output  1  write enable
- mem_waddr  output  ADDR_W-2  word index
- mem_wstrb  output  4  byte-lane strobes
- mem_wdata  output  32  store data shifted into lanes
- mem_ack  input  1  memory completes transaction this cycle
- mem_rdata  input  32  full read word, valid with mem_ack
- resp_valid  output  1  response valid
- resp_ready  input  1  writeback accepts response
- resp_rdata  output  32  extended load data, 0 for stores/errors
- resp_err  output  2  00 ok, 01 misaligned, 10 access fault, 11 illegal func3

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_wstrb=0, mem_waddr=0, mem_wdata=0; resp_valid=0, resp_rdata=0, resp_err=00; timeout counter=0.
- States: IDLE, MEM, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid, capture request and check it, in this priority:
  - Illegal func3 (loads: 011,110,111; stores: any value >010) -> err 11.
  - Misaligned (half: addr[0]!=0; word: addr[1:0]!=0) -> err 01.
  - Out of range (addr[31:ADDR_W]!=0) -> err 10.
  - Any error -> RESP next cycle, with no mem_req ever asserted.
  - Otherwise -> MEM; mem_req=1 in the next cycle.
- MEM signal values:
  - mem_waddr = addr[ADDR_W-1:2].
  - Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - mem_wdata = req_wdata<<(8*addr[1:0]).
  - mem_we = is_store. mem_wstrb is driven for loads as well.
  - All mem_* outputs are held stable until ack.
- MEM, mem_ack=1:
  - mem_req drops next cycle.
  - For loads, select the lane by addr[1:0] and sign- or zero-extend per func3; register into resp_rdata.
  - err 00; -> RESP.
- MEM timeout: counter increments each MEM cycle without ack. When it reaches TIMEOUT-1 with no ack: deassert mem_req, err 10, resp_rdata 0, -> RESP. If ack and timeout occur in the same cycle, ack wins.
- RESP: resp_valid=1, outputs held until resp_ready=1; then -> IDLE, resp_valid=0 next cycle. No back-to-back acceptance in the RESP cycle.
- Latency (good access, 0-wait memory acking in the first mem_req cycle): accept at T0, mem_req T1, resp_valid T2. Error response: resp_valid T1.
- resp_rdata is 0 for stores and errors.
- Reset mid-MEM or mid-RESP: immediate return to reset values. No memory write may be issued after rst_n falls.
- mem_ack outside MEM is ignored.

Test Plan:
- Aligned LW: addr=0x10, memory acks 1 cycle after mem_req with rdata 0x8081_8283 -> mem_waddr=4, wstrb=1111, mem_we=0; resp_rdata=0x8081_8283, err 00, resp_valid 2 cycles after mem_req rises.
- Byte/half extension: LB at 0x13 with rdata 0x80_00_00_00 -> 0xFFFF_FF80; LBU at same address -> 0x0000_0080; LH at 0x12 with rdata 0xF00D_0000 -> 0xFFFF_F00D; LHU -> 0x0000_F00D.
- Stores: SB addr=0x7, wdata=0x1234_56AB -> wstrb=1000, mem_wdata=0xAB00_0000, mem_we=1; SH addr=0x6 wdata=0xBEEF -> wstrb=1100, mem_wdata=0xBEEF_0000; resp_rdata=0.
- Faults: LW at 0x2 -> err 01; LH at 0x1000 -> err 10; load func3=011 -> err 11; all with resp_valid at T1 and mem_req never asserted.
- Timeout and backpressure: no ack for TIMEOUT=16 cycles -> mem_req drops after 16 cycles, err 10; hold resp_ready=0 for 5 cycles -> resp stays stable, req_ready=0 throughout.
- Async reset asserted while in MEM with mem_req=1 -> mem_req, resp_valid go 0 immediately; after release, req_ready=1 and a fresh LW completes normally.
